// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key two-flop synchroniser, stable-time debounce FSM,
// registered active-low level output and one-cycle active-low press strobe.
module key_conditioner #(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [NUM_KEYS-1:0] Key_n,
    output logic [NUM_KEYS-1:0] Level_n,
    output logic [NUM_KEYS-1:0] Press_n
);

    // The sample that first differs already counts as one, so a pending state
    // starts at 1 and accepts on reaching DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               ACCEPT_NOW = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_DOWN_PEND = 2'd1,
        ST_DOWN      = 2'd2,
        ST_UP_PEND   = 2'd3
    } state_e;

    logic [NUM_KEYS-1:0] s1_q, s1_d;
    logic [NUM_KEYS-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = Key_n;
        s2_d = s1_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;

        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                state_q <= ST_UP;
                cnt_q   <= '0;
                level_q <= 1'b1;
                press_q <= 1'b1;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            press_d = 1'b1;
            unique case (state_q)
                ST_UP: begin
                    if (!s2_q[i]) begin
                        if (ACCEPT_NOW) begin
                            state_d = ST_DOWN;
                            level_d = 1'b0;
                            press_d = 1'b0;
                        end else begin
                            state_d = ST_DOWN_PEND;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_DOWN_PEND: begin
                    if (s2_q[i]) begin
                        state_d = ST_UP;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_DOWN;
                        level_d = 1'b0;
                        press_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DOWN: begin
                    if (s2_q[i]) begin
                        if (ACCEPT_NOW) begin
                            state_d = ST_UP;
                            level_d = 1'b1;
                        end else begin
                            state_d = ST_UP_PEND;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_UP_PEND: begin
                    if (!s2_q[i]) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_UP;
                        level_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end
            endcase
        end

        assign Level_n[i] = level_q;
        assign Press_n[i] = press_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner against a sample-window
// reference model: a key flips once its last DEBOUNCE_CYCLES synchronised samples all differ.
module tb_key_conditioner;

    localparam int unsigned NK = 3;
    localparam int unsigned DB = 4;
    localparam int unsigned CW = 3;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic [NK-1:0] Key_n;
    logic [NK-1:0] Level_n;
    logic [NK-1:0] Press_n;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .Key_n  (Key_n),
        .Level_n(Level_n),
        .Press_n(Press_n)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Key values captured at each clock edge since reset, preceded by the two
    // reset-value synchroniser samples; the FSM at an edge sees the entry two back.
    logic [NK-1:0] hist[$];
    logic [NK-1:0] m_level;
    logic [NK-1:0] m_press;

    task automatic model_reset();
        hist.delete();
        hist.push_back('1);
        hist.push_back('1);
        m_level = '1;
        m_press = '1;
    endtask

    task automatic model_edge(input logic [NK-1:0] k);
        int  idx;
        bit  all_diff;
        hist.push_back(k);
        m_press = '1;
        idx = hist.size() - 3;
        for (int i = 0; i < int'(NK); i++) begin
            if (idx - int'(DB) + 1 >= 0) begin
                all_diff = 1'b1;
                for (int j = 0; j < int'(DB); j++) begin
                    if (hist[idx - j][i] == m_level[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    if (!m_level[i]) m_press[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive at the falling edge, advance one rising edge, check at the next falling edge.
    task automatic tick(input logic [NK-1:0] k);
        Key_n = k;
        @(posedge Clock);
        if (Reset_n) model_edge(k);
        else model_reset();
        @(negedge Clock);
        check("level", Level_n, m_level);
        check("press", Press_n, m_press);
    endtask

    task automatic async_reset(input int hold_cycles);
        #2 Reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_level", Level_n, 3'b111);
        check("rst_async_press", Press_n, 3'b111);
        repeat (hold_cycles) tick(Key_n);
        Reset_n = 1'b1;
    endtask

    initial begin
        int first;
        int pulses;
        int hold[NK];
        logic [NK-1:0] k;

        Reset_n = 1'b0;
        Key_n   = 3'b000;
        model_reset();
        @(negedge Clock);
        for (int i = 0; i < 10; i++) begin
            tick(3'b000);
            check("rst_hold_level", Level_n, 3'b111);
        end
        repeat (3) tick(3'b111);
        Reset_n = 1'b1;
        repeat (6) tick(3'b111);

        // Clean press on key 0
        first = -1; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(3'b110);
            if (!Press_n[0]) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        check_int("press0_edge", first, 5);
        check_int("press0_count", pulses, 1);

        // Release of key 0
        first = -1; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick(3'b111);
            if (first < 0 && Level_n[0]) first = i;
            if (!Press_n[0]) pulses++;
        end
        check_int("release0_edge", first, 5);
        check_int("release0_nostrobe", pulses, 0);

        // Short high glitch while held down
        repeat (12) tick(3'b110);
        repeat (3) tick(3'b111);
        repeat (10) begin
            tick(3'b110);
            check("glitch_level", Level_n, 3'b110);
        end
        repeat (12) tick(3'b111);

        // Bouncing key 1
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick(((i / 2) % 2) != 0 ? 3'b111 : 3'b101);
            if (!Press_n[1]) pulses++;
        end
        check_int("bounce_nopulse", pulses, 0);
        first = -1; pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick(3'b101);
            if (!Press_n[1]) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        check_int("bounce_edge", first, 5);
        check_int("bounce_count", pulses, 1);
        repeat (12) tick(3'b111);

        // Keys 0 and 1 together
        first = -1;
        for (int i = 0; i < 12; i++) begin
            tick(3'b100);
            if (first < 0 && Press_n == 3'b100) first = i;
        end
        check_int("simul_edge", first, 5);
        repeat (12) tick(3'b111);

        // Reset in the middle of a debounce on key 2
        repeat (4) tick(3'b011);
        async_reset(2);
        first = -1; pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick(3'b011);
            if (!Press_n[2]) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        check_int("rstmid_edge", first, 5);
        check_int("rstmid_count", pulses, 1);
        repeat (12) tick(3'b111);

        // Random bouncy keys with occasional asynchronous resets
        k = '1;
        for (int i = 0; i < int'(NK); i++) hold[i] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < int'(NK); i++) begin
                if (hold[i] == 0) begin
                    k[i]    = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 9));
                end
                hold[i]--;
            end
            tick(k);
            if ($urandom_range(0, 299) == 0) async_reset(int'($urandom_range(1, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
